// File: rtl/mem_stage.sv
// Memory stage of an RV32I pipeline.
// It does three jobs:
//   - forwards ALU results straight to writeback;
//   - issues byte, half and word loads/stores to a RAM that answers with an ack;
//   - flags misaligned accesses and RAM timeouts on mem_err.
module mem_stage #(
    parameter int ADDR_W      = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_rd_addr,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wstrb,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ack,
    output logic              wb_valid,
    output logic [4:0]        wb_rd_addr,
    output logic [31:0]       wb_data,
    output logic              mem_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic [1:0]         r_lane;
    logic [4:0]         r_rd;
    logic               r_is_load;

    // Undefined width codes are rejected the same way as misaligned ones.
    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return (a != 2'b00);
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] f_wstrb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the low byte/half lets the strobes pick the lane, so no shifter is needed.
    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rdata);
        logic [31:0] w_sh;
        w_sh = rdata >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{24{w_sh[7]}}, w_sh[7:0]};
            3'b100:  return {24'b0, w_sh[7:0]};
            3'b001:  return {{16{w_sh[15]}}, w_sh[15:0]};
            3'b101:  return {16'b0, w_sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    // Ready is derived straight from the state register, so the EX stage stalls outside IDLE.
    assign ex_ready = (r_state == IDLE);

    // Control FSM; RAM-side and writeback outputs are all registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_funct3   <= 3'b0;
            r_lane     <= 2'b0;
            r_rd       <= 5'b0;
            r_is_load  <= 1'b0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 32'b0;
            ram_wstrb  <= 4'b0;
            wb_valid   <= 1'b0;
            wb_rd_addr <= 5'b0;
            wb_data    <= 32'b0;
            mem_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!ex_is_load && !ex_is_store) begin
                            wb_valid   <= 1'b1;
                            wb_data    <= ex_alu_result;
                            wb_rd_addr <= ex_rd_addr;
                        end else if (f_misaligned(ex_funct3, ex_alu_result[1:0])) begin
                            mem_err <= 1'b1;
                        end else begin
                            r_state   <= ACCESS;
                            r_cnt     <= '0;
                            r_funct3  <= ex_funct3;
                            r_lane    <= ex_alu_result[1:0];
                            r_rd      <= ex_rd_addr;
                            r_is_load <= ex_is_load && !ex_is_store;
                            ram_req   <= 1'b1;
                            ram_we    <= ex_is_store;
                            ram_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                            ram_wdata <= f_wdata(ex_funct3, ex_store_data);
                            ram_wstrb <= ex_is_store ? f_wstrb(ex_funct3, ex_alu_result[1:0]) : 4'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (ram_ack) begin
                        ram_req   <= 1'b0;
                        ram_we    <= 1'b0;
                        ram_wstrb <= 4'b0;
                        r_state   <= RESP;
                        // Loads to x0 still complete on the bus but never reach writeback.
                        if (r_is_load && (r_rd != 5'd0)) begin
                            wb_valid   <= 1'b1;
                            wb_data    <= f_load(r_funct3, r_lane, ram_rdata);
                            wb_rd_addr <= r_rd;
                        end
                    end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        ram_req   <= 1'b0;
                        ram_we    <= 1'b0;
                        ram_wstrb <= 4'b0;
                        mem_err   <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
// Stimulus pushes expected writeback/error events into a queue;
// an independent monitor pops and compares them whenever the stage emits one.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ram_req, ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        mem_err;

    typedef struct {
        logic        err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_stage #(.ADDR_W(16), .ACK_TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every wb_valid or mem_err pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (wb_valid || mem_err) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: wb_valid=%0b mem_err=%0b wb_data=0x%08h, expected no output (t=%0t)",
                         wb_valid, mem_err, wb_data, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_mem_err", 32'(mem_err), 32'(mon_e.err));
                chk("sb_wb_valid", 32'(wb_valid), 32'(!mon_e.err));
                if (!mon_e.err) begin
                    chk("sb_wb_rd", 32'(wb_rd_addr), 32'(mon_e.rd));
                    chk("sb_wb_data", wb_data, mon_e.data);
                end
            end
        end
    end

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.err = 1'b0; e.rd = rd; e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.err = 1'b1; e.rd = 5'd0; e.data = 32'd0;
        sb_q.push_back(e);
    endtask

    // Presents one EX transfer for a single cycle; returns at posedge+1 after the accept edge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        chk("ready_at_issue", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_alu_result = a; ex_store_data = d; ex_rd_addr = rd;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    endtask

    // Holds off ack for 'cycles' cycles while checking the request stays stable, then acks once.
    task automatic ram_wait(input int cycles, input logic [31:0] rdata, input logic [15:0] exp_addr);
        for (int i = 0; i <= cycles; i++) begin
            chk("req_held", 32'(ram_req), 32'd1);
            chk("addr_stable", 32'(ram_addr), 32'(exp_addr));
            chk("ready_low_access", 32'(ex_ready), 32'd0);
            if (i < cycles) begin
                @(posedge clk); #1;
            end
        end
        ram_ack = 1'b1; ram_rdata = rdata;
        @(posedge clk); #1;
        ram_ack = 1'b0; ram_rdata = 32'hDEAD_0000;
        chk("req_dropped", 32'(ram_req), 32'd0);
        chk("ready_low_resp", 32'(ex_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_back", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        reset_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = 3'b0; ex_alu_result = 32'b0; ex_store_data = 32'b0; ex_rd_addr = 5'b0;
        ram_rdata = 32'b0; ram_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_req", 32'(ram_req), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_wstrb", 32'(ram_wstrb), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd_addr), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(ex_ready), 32'd1);

        // ALU pass-through
        push_wb(5'd5, 32'h0000_1234);
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        chk("pt_ready", 32'(ex_ready), 32'd1);
        chk("pt_no_req", 32'(ram_req), 32'd0);

        // LB addr 3: top byte 0x80 sign-extends
        push_wb(5'd7, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0003, 32'h0, 5'd7);
        chk("lb_we", 32'(ram_we), 32'd0);
        ram_wait(2, 32'h80FF_FFFF, 16'h0000);

        // SH addr 6: upper half lanes, data replicated
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h0000_ABCD, 5'd1);
        chk("sh_wstrb", 32'(ram_wstrb), 32'h0000_000C);
        chk("sh_wdata", ram_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(ram_we), 32'd1);
        ram_wait(1, 32'h0, 16'h0004);

        // SB addr 1
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678, 5'd1);
        chk("sb_wstrb", 32'(ram_wstrb), 32'h0000_0002);
        chk("sb_wdata", ram_wdata, 32'h7878_7878);
        ram_wait(0, 32'h0, 16'h0000);

        // SW addr 8
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 5'd1);
        chk("sw_wstrb", 32'(ram_wstrb), 32'h0000_000F);
        chk("sw_wdata", ram_wdata, 32'hDEAD_BEEF);
        ram_wait(0, 32'h0, 16'h0008);

        // LBU addr 1 zero-extends
        push_wb(5'd10, 32'h0000_00A5);
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 5'd10);
        ram_wait(1, 32'h0000_A500, 16'h0100);

        // LH addr 2 sign-extends
        push_wb(5'd11, 32'hFFFF_8001);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0, 5'd11);
        ram_wait(0, 32'h8001_0000, 16'h0020);

        // LW to x0: access completes, no writeback
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd0);
        ram_wait(1, 32'h1111_2222, 16'h0010);

        // LW misaligned
        push_err();
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0, 5'd4);
        chk("lw_mis_no_req", 32'(ram_req), 32'd0);
        chk("lw_mis_ready", 32'(ex_ready), 32'd1);

        // Undefined funct3 011
        push_err();
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd4);
        chk("f3_bad_no_req", 32'(ram_req), 32'd0);

        // Stray ack while idle is ignored
        ram_ack = 1'b1;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        chk("stray_ack_ready", 32'(ex_ready), 32'd1);
        chk("stray_ack_no_req", 32'(ram_req), 32'd0);

        // LW that is never acked
        push_err();
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd3);
        cnt = 0;
        while (ram_req && cnt < 1000) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("timeout_req_cycles", 32'(cnt), 32'd255);
        chk("timeout_ready", 32'(ex_ready), 32'd1);

        // Reset mid-access
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd6);
        chk("pre_reset_req", 32'(ram_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_req", 32'(ram_req), 32'd0);
        chk("async_reset_ready", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset2", 32'(ex_ready), 32'd1);

        // LHU addr 2 after reset
        push_wb(5'd9, 32'h0000_FFFF);
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd9);
        ram_wait(1, 32'hFFFF_0000, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, default 16, RAM byte-address width.
REQ-002 Parameter ACK_TIMEOUT, default 255, maximum cycles to wait for ram_ack before a bus error.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ex_valid  input  1  EX result presented this cycle.
REQ-006 ex_ready  output  1  stage can accept; the EX stage stalls while low.
REQ-007 ex_is_load / ex_is_store  input  1 each  memory op type; both low means ALU pass-through.
REQ-008 ex_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 ex_alu_result  input  32  load/store effective address, or pass-through result.
REQ-010 ex_store_data  input  32  rs2 value for stores.
REQ-011 ex_rd_addr  input  5  destination register.
REQ-012 ram_req  output  1  RAM access request.
REQ-013 ram_we  output  1  write qualifier.
REQ-014 ram_addr  output  ADDR_W  word-aligned byte address.
REQ-015 ram_wdata  output  32  lane-shifted store data.
REQ-016 ram_wstrb  output  4  byte enables.
REQ-017 ram_rdata  input  32  read data, valid with ram_ack.
REQ-018 ram_ack  input  1  access complete.
REQ-019 wb_valid  output  1  one-cycle result pulse to writeback.
REQ-020 wb_rd_addr  output  5  destination register.
REQ-021 wb_data  output  32  result.
REQ-022 mem_err  output  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-023 States SHALL be IDLE, ACCESS and RESP; ex_ready SHALL equal (state==IDLE).
REQ-024 A transfer SHALL be accepted when ex_valid and ex_ready are both high.
REQ-025 A pass-through accept SHALL produce wb_valid with wb_data=ex_alu_result and wb_rd_addr=ex_rd_addr on the next cycle; state stays IDLE.
REQ-026 A memory accept SHALL move the FSM to ACCESS and register the address, data, funct3 and rd.
REQ-027 In ACCESS, ram_req SHALL be held high with stable ram_addr, ram_we, ram_wdata and ram_wstrb until the cycle ram_ack is sampled high.
REQ-028 On ram_ack, the FSM SHALL move to RESP; RESP SHALL pulse wb_valid for a load (none for a store) and return to IDLE.
REQ-029 ram_addr SHALL be {addr[ADDR_W-1:2],2'b00}.
REQ-030 Store wstrb SHALL be: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
REQ-031 Store wdata SHALL replicate the low byte (B) or low half (H) across lanes.
REQ-032 Load data SHALL be the selected lane: sign-extended for B/H, zero-extended for BU/HU, and the unchanged word for W.
REQ-033 A misaligned access (H with addr[0]=1; W with addr[1:0]!=0) SHALL not request RAM; mem_err pulses the next cycle, with no wb_valid.
REQ-034 An ACCESS counter SHALL count ram_req cycles; reaching ACK_TIMEOUT without ack SHALL drop ram_req, pulse mem_err, suppress wb_valid and return to IDLE.
REQ-035 A load with ex_rd_addr=0 SHALL complete the RAM access but suppress wb_valid.
REQ-036 ram_ack outside ACCESS SHALL be ignored.
REQ-037 An undefined funct3 (011, 110, 111) on a memory op SHALL be treated as misaligned.

Reset
REQ-038 Reset assertion SHALL force state IDLE, counter 0, and ram_req, ram_we, wb_valid, mem_err, ram_wstrb to 0, with wb_data, wb_rd_addr, ram_addr and ram_wdata cleared to 0.
REQ-039 Reset asserted mid-ACCESS SHALL drop ram_req immediately (asynchronously) and discard the access.
REQ-040 ex_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-041 Pass-through ex_alu_result=0x1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd_addr=5.
REQ-042 LB addr 0x0003, ram_rdata=0x80FFFFFF, ack after 2 cycles -> ram_addr=0x0000, wb_data=0xFFFFFF80, one wb_valid pulse, ex_ready low throughout.
REQ-043 SH addr 0x0006, data 0x0000ABCD -> ram_wstrb=1100, ram_wdata=0xABCDABCD, ram_we=1, no wb_valid.
REQ-044 LW addr 0x0002 -> no ram_req, mem_err pulse, no wb_valid.
REQ-045 LW with ram_ack never asserted -> ram_req high exactly 255 cycles, then mem_err pulse, then ex_ready=1.
REQ-046 reset_n low during ACCESS -> ram_req=0 in the same cycle; after release, new LHU addr 0x0002 of 0xFFFF0000 -> wb_data=0x0000FFFF.
